// File: rtl/rfdp_rd_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : rfdp_rd_stream_if
//  Purpose  : Bundle of command, RAM read-port and stream signals used by
//             rfdp_rd_stream. The master side is the block itself; the slave
//             side is the surrounding logic (command source, RAM, consumer).
//  Revision : 1.0  initial release
// ============================================================================
interface rfdp_rd_stream_if #(
   parameter int DEPTH = 8192,
   parameter int WIDTH = 64
);
   localparam int AW = $clog2(DEPTH);

   // command channel
   logic             cmd_valid;
   logic             cmd_ready;
   logic [AW-1:0]    cmd_addr;
   logic [AW:0]      cmd_len;
   logic             cmd_err;

   // RAM read port (port A)
   logic             CENA;
   logic [AW-1:0]    AA;
   logic [WIDTH-1:0] QA;

   // output stream and status
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;
   logic             m_last;
   logic             busy;
   logic             done;

   modport master (
      input  cmd_valid, cmd_addr, cmd_len, QA, m_ready,
      output cmd_ready, cmd_err, CENA, AA, m_valid, m_data, m_last, busy, done
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_len, QA, m_ready,
      input  cmd_ready, cmd_err, CENA, AA, m_valid, m_data, m_last, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/rfdp_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module   : rfdp_rd_stream
//  Purpose  : Turns a {start address, length} command into a burst of reads
//             on a one-cycle-latency RAM port and streams the returned words
//             out through a valid/ready interface. A 2-entry FIFO plus a
//             credit check keeps reads from ever outrunning the consumer.
//  Revision : 1.0  initial release
// ============================================================================
module rfdp_rd_stream #(
   parameter int DEPTH = 8192,
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rstn,
   rfdp_rd_stream_if.master bus
);
   localparam int AW  = $clog2(DEPTH);
   localparam int AW1 = AW + 1;

   localparam logic [1:0]    c_IDLE      = 2'd0;
   localparam logic [1:0]    c_READ      = 2'd1;
   localparam logic [1:0]    c_DRAIN     = 2'd2;
   localparam logic [AW:0]   c_DEPTH     = AW1'(DEPTH);
   localparam logic [AW:0]   c_LEN_ONE   = AW1'(1);
   localparam logic [AW-1:0] c_ADDR_ONE  = AW'(1);
   localparam logic [AW-1:0] c_LAST_ADDR = AW'(DEPTH - 1);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [AW-1:0]    r_addr;        // next address to read
   logic [AW-1:0]    r_aa_hold;     // last address driven, shown while idle
   logic [AW:0]      r_len;
   logic [AW:0]      r_issued;
   logic [AW:0]      r_popped;
   logic             r_inflight;    // a read was issued last cycle
   logic [WIDTH-1:0] r_fifo [2];
   logic             r_wp;
   logic             r_rp;
   logic [1:0]       r_cnt;
   logic             r_err;
   logic             r_done;

   logic             w_cmd_fire;
   logic             w_cmd_bad;
   logic             w_cmd_zero;
   logic             w_cmd_ok;
   logic             w_issue;
   logic             w_push;
   logic             w_pop;
   logic             w_last;
   logic [2:0]       w_occ;
   logic [AW-1:0]    w_addr_inc;

   // command decode: range violations take priority over a zero length
   assign w_cmd_fire = bus.cmd_valid && (r_state == c_IDLE);
   assign w_cmd_bad  = ({1'b0, bus.cmd_addr} >= c_DEPTH) || (bus.cmd_len > c_DEPTH);
   assign w_cmd_zero = !w_cmd_bad && (bus.cmd_len == '0);
   assign w_cmd_ok   = w_cmd_fire && !w_cmd_bad && !w_cmd_zero;

   // FIFO traffic: the RAM answers exactly one cycle after each issued read
   assign w_push = r_inflight;
   assign w_pop  = (r_cnt != 2'd0) && bus.m_ready;
   assign w_last = (r_cnt != 2'd0) && (r_popped == (r_len - c_LEN_ONE));

   // slots committed after this cycle's pop, before any new issue
   assign w_occ = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};

   assign w_addr_inc = (r_addr == c_LAST_ADDR) ? '0 : (r_addr + c_ADDR_ONE);

   // state register
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE: begin
            if (w_cmd_ok) begin
               w_state_nxt = c_READ;
            end
         end
         c_READ: begin
            if (w_issue && ((r_issued + c_LEN_ONE) == r_len)) begin
               w_state_nxt = c_DRAIN;
            end
         end
         c_DRAIN: begin
            if (w_pop && w_last) begin
               w_state_nxt = c_IDLE;
            end
         end
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // output logic: issue a read only with words left and a free FIFO slot
   always_comb begin
      w_issue = 1'b0;
      if ((r_state == c_READ) && (r_issued < r_len) && (w_occ < 3'd2)) begin
         w_issue = 1'b1;
      end
   end

   assign bus.cmd_ready = (r_state == c_IDLE);
   assign bus.busy      = (r_state != c_IDLE);
   assign bus.CENA      = !w_issue;
   assign bus.AA        = w_issue ? r_addr : r_aa_hold;
   assign bus.cmd_err   = r_err;
   assign bus.done      = r_done;
   assign bus.m_valid   = (r_cnt != 2'd0);
   assign bus.m_data    = r_fifo[r_rp];
   assign bus.m_last    = w_last;

   // burst bookkeeping: address, length and issue/pop counters
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_addr     <= '0;
         r_aa_hold  <= '0;
         r_len      <= '0;
         r_issued   <= '0;
         r_popped   <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_cmd_ok) begin
            r_addr   <= bus.cmd_addr;
            r_len    <= bus.cmd_len;
            r_issued <= '0;
            r_popped <= '0;
         end else begin
            if (w_issue) begin
               r_addr    <= w_addr_inc;
               r_aa_hold <= r_addr;
               r_issued  <= r_issued + c_LEN_ONE;
            end
            if (w_pop) begin
               r_popped <= r_popped + c_LEN_ONE;
            end
         end
      end
   end

   // two-entry output FIFO fed from the RAM data bus
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_fifo[0] <= '0;
         r_fifo[1] <= '0;
         r_wp      <= 1'b0;
         r_rp      <= 1'b0;
         r_cnt     <= 2'd0;
      end else begin
         if (w_push) begin
            r_fifo[r_wp] <= bus.QA;
            r_wp         <= ~r_wp;
         end
         if (w_pop) begin
            r_rp <= ~r_rp;
         end
         r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   // one-cycle status pulses for rejected commands and finished bursts
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_err  <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_err  <= w_cmd_fire && w_cmd_bad;
         r_done <= (w_cmd_fire && w_cmd_zero) ||
                   ((r_state == c_DRAIN) && w_pop && w_last);
      end
   end
endmodule
`default_nettype wire
